// File: rtl/sw_reset_pkg.sv
// Shared types and constants for the software-reset initiator.
package sw_reset_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_READ,
        ST_WRITE,
        ST_POLL,
        ST_DONE,
        ST_ERROR
    } sw_reset_state_t;

    localparam logic SW_RESET_ADDR  = 1'b0;
    localparam int   SW_RESET_MAX_W = 1024;

    // Wide enough for any supported WIDTH; callers cast down to their width.
    function automatic logic [SW_RESET_MAX_W-1:0] sw_reset_wdata_ones();
        return '1;
    endfunction

endpackage

// File: rtl/sw_reset_initiator_if.sv
// Avalon-MM port between the initiator and the 1-word software-reset slave.
interface sw_reset_initiator_if #(
    parameter int WIDTH = 32
);
    logic                 master_address;
    logic [WIDTH-1:0]     master_writedata;
    logic [WIDTH/8-1:0]   master_byteenable;
    logic                 master_read;
    logic                 master_write;
    logic                 master_readdata;
    logic                 master_waitrequest;

    modport master (
        output master_address, master_writedata, master_byteenable,
        output master_read, master_write,
        input  master_readdata, master_waitrequest
    );

    modport slave (
        input  master_address, master_writedata, master_byteenable,
        input  master_read, master_write,
        output master_readdata, master_waitrequest
    );
endinterface

// File: rtl/sw_reset_timeout.sv
// Per-phase timeout counter: clear restarts it, expired flags the all-ones count.
module sw_reset_timeout #(
    parameter int LOG2_TIMEOUT = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [LOG2_TIMEOUT-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + LOG2_TIMEOUT'(1);
        end
    end

    assign expired = &cnt_q;
endmodule

// File: rtl/sw_reset_initiator.sv
// Runs the wait-idle / write / poll handshake against the software-reset slave
// and reports done or error; every output comes straight from a register.
module sw_reset_initiator
    import sw_reset_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int LOG2_TIMEOUT = 12,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            attempts,
    sw_reset_initiator_if.master  m
);
    sw_reset_state_t state_q, state_d;
    logic       read_q, read_d;
    logic       write_q, write_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic [2:0] attempts_q, attempts_d;
    logic       tmr_clr, tmr_en, tmr_expired;
    logic       xfer_ok, timeout, retry;

    // A read only completes while it is actually on the bus, so the idle
    // cycle after a timeout can never be mistaken for a completion.
    assign xfer_ok = read_q & ~m.master_waitrequest;
    assign timeout = tmr_expired & ~xfer_ok;
    assign tmr_en  = (state_q == ST_PRE_READ) || (state_q == ST_POLL);

    sw_reset_timeout #(.LOG2_TIMEOUT(LOG2_TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        attempts_d = attempts_q;
        tmr_clr    = 1'b0;
        retry      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d    = ST_PRE_READ;
                    attempts_d = '0;
                    tmr_clr    = 1'b1;
                end
            end
            ST_PRE_READ: begin
                if (xfer_ok)      state_d = ST_WRITE;
                else if (timeout) retry   = 1'b1;
            end
            ST_WRITE: begin
                // The slave stalls for as long as write is held, so a stalled
                // write is withdrawn and the idle check repeated instead.
                tmr_clr = 1'b1;
                state_d = m.master_waitrequest ? ST_PRE_READ : ST_POLL;
            end
            ST_POLL: begin
                if (xfer_ok) begin
                    if (m.master_readdata) state_d = ST_DONE;
                end else if (timeout) begin
                    retry = 1'b1;
                end
            end
            ST_DONE, ST_ERROR: state_d = ST_IDLE;
            default:           state_d = ST_IDLE;
        endcase

        if (retry) begin
            tmr_clr = 1'b1;
            if (attempts_q < 3'(MAX_RETRIES)) begin
                attempts_d = attempts_q + 3'd1;
                state_d    = ST_PRE_READ;
            end else begin
                state_d    = ST_ERROR;
            end
        end

        read_d  = ((state_d == ST_PRE_READ) || (state_d == ST_POLL)) && !retry;
        write_d = (state_d == ST_WRITE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            attempts_q <= '0;
        end else begin
            state_q    <= state_d;
            read_q     <= read_d;
            write_q    <= write_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            attempts_q <= attempts_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign attempts = attempts_q;

    assign m.master_address    = SW_RESET_ADDR;
    assign m.master_read       = read_q;
    assign m.master_write      = write_q;
    assign m.master_byteenable = '1;
    assign m.master_writedata  = write_q ? WIDTH'(sw_reset_wdata_ones()) : '0;
endmodule

// File: tb/tb_sw_reset_initiator.sv
// Randomized bench for sw_reset_initiator with a behavioural reset-slave model.
module tb_sw_reset_initiator;
    localparam int W     = 32;
    localparam int S_L2  = 6;
    localparam int S_MAX = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req = 1'b0, req_s = 1'b0;
    logic busy, done, error, busy_s, done_s, error_s;
    logic [2:0] attempts, attempts_s;
    int checks = 0, errors = 0;
    int unsigned cyc = 0;

    sw_reset_initiator_if #(.WIDTH(W)) bus ();
    sw_reset_initiator_if #(.WIDTH(W)) bus_s ();

    sw_reset_initiator #(.WIDTH(W)) u_dut (
        .clk(clk), .reset(reset), .req(req), .busy(busy), .done(done),
        .error(error), .attempts(attempts), .m(bus)
    );
    sw_reset_initiator #(.WIDTH(W), .LOG2_TIMEOUT(S_L2), .MAX_RETRIES(S_MAX)) u_stk (
        .clk(clk), .reset(reset), .req(req_s), .busy(busy_s), .done(done_s),
        .error(error_s), .attempts(attempts_s), .m(bus_s)
    );

    always #5 clk = ~clk;

    // Reset slave: an accepted write starts an R-cycle reset during which
    // waitrequest is high; the released level reads back three cycles late.
    int  cnt = 0, r_cur = 256, pre_val = 0, wr_base = 0;
    bit  pre_en = 1'b0, frc = 1'b0;
    int  wr_cycles = 0, wr_acc = 0, wd_bad = 0, hold_bad = 0;
    logic prev_wr = 1'b0, d1 = 1'b1, d2 = 1'b1, d3 = 1'b1;

    assign bus.master_waitrequest = (cnt != 0) || (frc && bus.master_write && wr_cycles == wr_base);
    assign bus.master_readdata    = d3;
    assign bus_s.master_waitrequest = 1'b1;
    assign bus_s.master_readdata    = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.master_write) begin
            wr_cycles <= wr_cycles + 1;
            if (bus.master_writedata !== {W{1'b1}}) wd_bad <= wd_bad + 1;
            if (prev_wr) hold_bad <= hold_bad + 1;
            if (!bus.master_waitrequest) wr_acc <= wr_acc + 1;
        end
        prev_wr <= bus.master_write;
        if (pre_en) cnt <= pre_val;
        else if (bus.master_write && !bus.master_waitrequest) cnt <= r_cur;
        else if (cnt != 0) cnt <= cnt - 1;
        d1 <= (cnt == 0);
        d2 <= d1;
        d3 <= d2;
    end

    // Reference: idle check finishes once the slave is free (never before
    // cycle 1), a stalled write costs two more cycles, then the write, the
    // R-cycle reset and three cycles of readback lag, then the DONE cycle.
    function automatic int exp_done(input int b, input int r, input bit f);
        int p, w;
        p = (b > 1) ? b : 1;
        w = f ? p + 3 : p + 1;
        return w + r + 5;
    endfunction

    task automatic run_seq(input int b, input int r, input bit force_w, input bit spam,
                           output int t_done, output int n_done, output int n_err,
                           output int n_wr, output int n_acc, output int extra_busy);
        int wc0, wa0, post;
        bit fin;
        int unsigned t0;
        r_cur = r; frc = force_w;
        t_done = -1; n_done = 0; n_err = 0; extra_busy = 0; fin = 0; post = 0;
        @(negedge clk);
        if (b >= 0) begin pre_val = b; pre_en = 1'b1; end
        @(negedge clk);
        pre_en = 1'b0; req = 1'b1; t0 = cyc;
        wr_base = wr_cycles; wc0 = wr_cycles; wa0 = wr_acc;
        for (int i = 1; i < 3000 && post < 8; i++) begin
            @(negedge clk);
            req = spam && busy && !done && !error && ($urandom_range(0, 1) == 1);
            if (fin) begin post++; if (busy) extra_busy++; end
            if (done) begin n_done++; if (t_done < 0) t_done = int'(cyc - t0); end
            if (error) n_err++;
            if (done || error) fin = 1'b1;
        end
        req = 1'b0; frc = 1'b0;
        n_wr = wr_cycles - wc0; n_acc = wr_acc - wa0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rst_pulses got %b%b want 00", done, error); end
        checks++; if (bus.master_read !== 1'b0 || bus.master_write !== 1'b0) begin errors++; $display("FAIL rst_rw got %b%b want 00", bus.master_read, bus.master_write); end
        checks++; if (attempts !== 3'd0) begin errors++; $display("FAIL rst_attempts got %0d want 0", attempts); end
        checks++; if (bus.master_address !== 1'b0 || bus.master_byteenable !== 4'hF) begin errors++; $display("FAIL rst_addr_be got %b %h want 0 f", bus.master_address, bus.master_byteenable); end
        checks++; if (bus.master_writedata !== '0) begin errors++; $display("FAIL rst_wdata got %h want 0", bus.master_writedata); end
        checks++; if (busy_s !== 1'b0 || bus_s.master_read !== 1'b0) begin errors++; $display("FAIL rst_stk got %b%b want 00", busy_s, bus_s.master_read); end
        reset = 1'b0;
    endtask

    task automatic check_seq(input string nm, input int b, input int r, input bit f, input bit spam);
        int t, nd, ne, nw, na, xb, e;
        run_seq(b, r, f, spam, t, nd, ne, nw, na, xb);
        e = exp_done(b, r, f);
        checks++; if (nd != 1 || ne != 0) begin errors++; $display("FAIL %s_outcome got done=%0d err=%0d want 1 0", nm, nd, ne); end
        checks++; if (t != e) begin errors++; $display("FAIL %s_latency got %0d want %0d (b=%0d r=%0d f=%0d)", nm, t, e, b, r, f); end
        checks++; if (na != 1 || nw != 1 + int'(f)) begin errors++; $display("FAIL %s_writes got acc=%0d beats=%0d want 1 %0d", nm, na, nw, 1 + int'(f)); end
        checks++; if (attempts !== 3'd0) begin errors++; $display("FAIL %s_attempts got %0d want 0", nm, attempts); end
        checks++; if (xb != 0) begin errors++; $display("FAIL %s_idle_after got %0d busy cycles want 0", nm, xb); end
    endtask

    task automatic test_idle();        check_seq("idle", 0, 256, 1'b0, 1'b0);   endtask
    task automatic test_busy_slave();  check_seq("busy_slave", 100, 256, 1'b0, 1'b0); endtask
    task automatic test_write_stall(); check_seq("wr_stall", 0, 64, 1'b1, 1'b0); endtask
    task automatic test_req_spam();    check_seq("spam", int'($urandom_range(0, 20)), 50, 1'b0, 1'b1); endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++)
            check_seq("rand", int'($urandom_range(0, 120)), int'($urandom_range(8, 300)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_timeout();
        int te = -1, gaps = 0, nd = 0, nw = 0, e;
        logic [2:0] att_mid = '0;
        int unsigned t0;
        e = 1 + (S_MAX + 1) * (2 ** S_L2);
        @(negedge clk); req_s = 1'b1; t0 = cyc;
        for (int i = 1; i < 600; i++) begin
            @(negedge clk);
            req_s = 1'b0;
            if (busy_s && !bus_s.master_read) gaps++;
            if (done_s) nd++;
            if (bus_s.master_write) nw++;
            if (i == 100) att_mid = attempts_s;
            if (error_s && te < 0) te = int'(cyc - t0);
            if (te >= 0 && i > te + 4) break;
        end
        checks++; if (te != e) begin errors++; $display("FAIL to_error_cycle got %0d want %0d", te, e); end
        checks++; if (attempts_s !== 3'(S_MAX)) begin errors++; $display("FAIL to_attempts got %0d want %0d", attempts_s, S_MAX); end
        checks++; if (att_mid !== 3'd1) begin errors++; $display("FAIL to_attempts_mid got %0d want 1", att_mid); end
        checks++; if (nd != 0 || nw != 0) begin errors++; $display("FAIL to_no_done_write got done=%0d wr=%0d want 0 0", nd, nw); end
        checks++; if (gaps != S_MAX + 1) begin errors++; $display("FAIL to_read_gaps got %0d want %0d", gaps, S_MAX + 1); end
    endtask

    task automatic test_reset_mid_poll();
        int wc0, rem, t, nd, ne, nw, na, xb;
        r_cur = 256;
        @(negedge clk); pre_val = 0; pre_en = 1'b1;
        @(negedge clk); pre_en = 1'b0; req = 1'b1; wc0 = wr_cycles;
        @(negedge clk); req = 1'b0;
        repeat (49) @(negedge clk);
        checks++; if (busy !== 1'b1 || bus.master_read !== 1'b1) begin errors++; $display("FAIL mid_poll_active got busy=%b rd=%b want 1 1", busy, bus.master_read); end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        checks++; if (busy !== 1'b0 || bus.master_read !== 1'b0 || bus.master_write !== 1'b0) begin errors++; $display("FAIL mid_rst_idle got busy=%b rd=%b wr=%b want 000", busy, bus.master_read, bus.master_write); end
        repeat (3) @(negedge clk);
        checks++; if (wr_cycles - wc0 != 1) begin errors++; $display("FAIL mid_rst_writes got %0d want 1", wr_cycles - wc0); end
        rem = cnt;
        run_seq(-1, 256, 1'b0, 1'b0, t, nd, ne, nw, na, xb);
        checks++; if (nd != 1 || ne != 0 || na != 1) begin errors++; $display("FAIL mid_rst_rerun got done=%0d err=%0d acc=%0d want 1 0 1", nd, ne, na); end
        checks++; if (t != exp_done(rem - 2, 256, 1'b0)) begin errors++; $display("FAIL mid_rst_latency got %0d want %0d", t, exp_done(rem - 2, 256, 1'b0)); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_busy_slave();
        test_write_stall();
        test_timeout();
        test_reset_mid_poll();
        test_req_spam();
        test_random();
        checks++; if (wd_bad != 0) begin errors++; $display("FAIL wdata_ones got %0d bad beats want 0", wd_bad); end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL write_held got %0d held beats want 0", hold_bad); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
